mux4_scan_arbiter: RTL and testbench
====================================

Name: mux4_scan_arbiter

Overview:
Round-robin request arbiter and sampler that sits directly upstream of the 4:1 mux built from 2:1 muxes. It drives the mux selects s1/s0 for the winning channel and waits a programmable settle time. It then samples the mux output o and presents the sampled bit downstream on a valid/ready handshake, tagged with its channel index.

Parameters:
SETTLE, 1, clock cycles between select change and sampling of mux_o (legal 1..15; 0 treated as 1)
CNT_W, 8, width of completed-sample counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  4  per-channel sample request, bit n = channel n (mux input i0..i3)
mux_o  in  1  output o of downstream 4:1 mux
out_ready  in  1  downstream consumer ready
s0  out  1  mux select LSB (registered)
s1  out  1  mux select MSB (registered)
grant  out  4  one-hot channel currently being sampled, 0 when idle
out_valid  out  1  sampled data valid
out_data  out  1  sampled value of mux_o
out_chan  out  2  channel index of out_data ({s1,s0} at capture)
sample_cnt  out  CNT_W  completed handshakes, wraps

Behaviour:
- Reset (async on rst_n low, released synchronously by design): state=IDLE; s0=s1=0; grant=0; out_valid=0; out_data=0; out_chan=0; sample_cnt=0; rr pointer ptr=0.
- All outputs registered; no combinational path from inputs to outputs.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE: if req!=0 at edge, winner = first set bit searching ptr, ptr+1, ... mod 4. Next cycle: {s1,s0}=winner, grant=1<<winner, settle counter=SETTLE-1, state=SETTLE. If req==0, remain IDLE; selects keep last value.
- SETTLE: if counter!=0, decrement. If counter==0 at edge: out_data<=mux_o, out_chan<=winner, out_valid<=1, state=HOLD.
- HOLD: out_valid, out_data, out_chan, selects, grant held stable until out_valid&&out_ready at an edge. On that edge: out_valid<=0, grant<=0, ptr<=(winner+1) mod 4, sample_cnt<=sample_cnt+1 (2^CNT_W-1 wraps to 0), state=IDLE.
- Latency with SETTLE=1: req sampled at edge k -> selects/grant valid after k -> mux_o sampled at edge k+1 -> out_valid high after k+1. General: out_valid after edge k+SETTLE.
- Min spacing between samples: SETTLE+2 cycles (one mandatory IDLE cycle after each handshake).
- req deasserted after grant: transaction completes normally; no abort.
- mux_o changing after capture does not affect out_data.
- out_ready high before out_valid: no effect; handshake only in HOLD.
- All four req high continuously: grants rotate 0,1,2,3,0,...
- rst_n low mid-transaction: immediate return to reset values, in-flight sample discarded, sample_cnt cleared.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle, no clock edge -> all outputs 0 immediately; release, req=0 for 5 cycles -> grant=0, out_valid=0.
- Single channel, SETTLE=1: req=4'b0100, mux model drives o=i2=1, out_ready=1 -> s1=1, s0=0, grant=0100 one cycle after req; out_valid=1, out_data=1, out_chan=2 one cycle later; sample_cnt=1.
- Round robin: req=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0, each SETTLE+2=3 cycles apart.
- Backpressure: out_ready=0 for 6 cycles while in HOLD, mux_o toggles -> out_valid, out_data, out_chan, selects stable; handshake on first out_ready=1 edge.
- Skip/pointer: grant ch1 completes, then req=4'b0011 -> ch0 granted (search 2,3,0); next with req=4'b0011 -> ch1.
- Reset mid-SETTLE with SETTLE=4 and sample_cnt=255 wrap check: 256 handshakes -> sample_cnt=0; rst_n pulse during SETTLE -> out_valid never asserts, ptr=0.

Source files
------------

// File: rtl/mux4_scan_arbiter_if.sv
// Handshake/bus bundle between the scan arbiter and its requester, mux and consumer.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mux4_scan_arbiter_if #(
   parameter int unsigned CNT_W = 8
);
   logic [3:0]       req;
   logic             mux_o;
   logic             out_ready;
   logic             s0;
   logic             s1;
   logic [3:0]       grant;
   logic             out_valid;
   logic             out_data;
   logic [1:0]       out_chan;
   logic [CNT_W-1:0] sample_cnt;

   modport master (
      output req, mux_o, out_ready,
      input  s0, s1, grant, out_valid, out_data, out_chan, sample_cnt
   );

   modport slave (
      input  req, mux_o, out_ready,
      output s0, s1, grant, out_valid, out_data, out_chan, sample_cnt
   );
endinterface

// File: rtl/mux4_scan_arbiter.sv
// Round-robin arbiter that steers a 4:1 mux, waits a settle time, samples the mux
// output and presents it downstream on a valid/ready handshake tagged with its channel.
module mux4_scan_arbiter #(
   parameter int unsigned SETTLE = 1,
   parameter int unsigned CNT_W  = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   mux4_scan_arbiter_if.slave  bus
);

   localparam int unsigned SETTLE_EFF = (SETTLE == 0) ? 1 : SETTLE;
   localparam logic [3:0]  SETTLE_LD  = 4'(SETTLE_EFF - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t           r_state;
   logic [1:0]       r_sel;
   logic [1:0]       r_ptr;
   logic [3:0]       r_grant;
   logic [3:0]       r_settle;
   logic             r_valid;
   logic             r_data;
   logic [1:0]       r_chan;
   logic [CNT_W-1:0] r_cnt;

   logic [1:0]       w_winner;
   logic [1:0]       w_idx;
   logic             w_found;

   // First requesting channel at or after the pointer; scanned backwards so the nearest wins.
   always_comb begin
      w_found  = 1'b0;
      w_winner = 2'd0;
      w_idx    = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         w_idx = r_ptr + 2'(i);
         if (bus.req[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_sel    <= 2'd0;
         r_ptr    <= 2'd0;
         r_grant  <= 4'd0;
         r_settle <= 4'd0;
         r_valid  <= 1'b0;
         r_data   <= 1'b0;
         r_chan   <= 2'd0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_sel    <= w_winner;
                  r_grant  <= 4'b0001 << w_winner;
                  r_settle <= SETTLE_LD;
                  r_state  <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (r_settle != 4'd0) begin
                  r_settle <= r_settle - 4'd1;
               end else begin
                  r_data  <= bus.mux_o;
                  r_chan  <= r_sel;
                  r_valid <= 1'b1;
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               // Everything stays frozen until the consumer takes the sample.
               if (bus.out_ready) begin
                  r_valid <= 1'b0;
                  r_grant <= 4'd0;
                  r_ptr   <= r_sel + 2'd1;
                  r_cnt   <= r_cnt + CNT_W'(1);
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.s0         = r_sel[0];
   assign bus.s1         = r_sel[1];
   assign bus.grant      = r_grant;
   assign bus.out_valid  = r_valid;
   assign bus.out_data   = r_data;
   assign bus.out_chan   = r_chan;
   assign bus.sample_cnt = r_cnt;

endmodule

// File: tb/tb_mux4_scan_arbiter.sv
// Directed bench for mux4_scan_arbiter: one instance with SETTLE=1, one with SETTLE=4.
module tb_mux4_scan_arbiter;

   logic clk;
   logic rst_n;
   logic rst_n_b;
   logic [3:0] r_pat_a;
   logic [3:0] r_pat_b;
   int n_checks;
   int n_fail;

   mux4_scan_arbiter_if #(.CNT_W(8)) bus_a ();
   mux4_scan_arbiter_if #(.CNT_W(8)) bus_b ();

   mux4_scan_arbiter #(.SETTLE(1), .CNT_W(8)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   mux4_scan_arbiter #(.SETTLE(4), .CNT_W(8)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n_b),
      .bus   (bus_b)
   );

   // 4:1 mux models: o = i[{s1,s0}]
   assign bus_a.mux_o = r_pat_a[{bus_a.s1, bus_a.s0}];
   assign bus_b.mux_o = r_pat_b[{bus_b.s1, bus_b.s0}];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] exp_pat;
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b1;
      rst_n_b  = 1'b1;
      r_pat_a  = 4'd0;
      r_pat_b  = 4'd0;
      bus_a.req = 4'd0; bus_a.out_ready = 1'b0;
      bus_b.req = 4'd0; bus_b.out_ready = 1'b0;

      // Asynchronous reset with no clock edge
      #3;
      rst_n   = 1'b0;
      rst_n_b = 1'b0;
      #1;
      chk("rst_valid", 32'(bus_a.out_valid), 32'd0);
      chk("rst_data",  32'(bus_a.out_data),  32'd0);
      chk("rst_chan",  32'(bus_a.out_chan),  32'd0);
      chk("rst_sel",   32'({bus_a.s1, bus_a.s0}), 32'd0);
      chk("rst_grant", 32'(bus_a.grant),     32'd0);
      chk("rst_cnt",   32'(bus_a.sample_cnt), 32'd0);
      chk("rst_b_valid", 32'(bus_b.out_valid), 32'd0);
      tick();
      rst_n   = 1'b1;
      rst_n_b = 1'b1;

      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_grant", 32'(bus_a.grant), 32'd0);
         chk("idle_valid", 32'(bus_a.out_valid), 32'd0);
      end

      // Single channel 2, out_ready already high
      r_pat_a = 4'b0100; bus_a.req = 4'b0100; bus_a.out_ready = 1'b1;
      tick();
      chk("single_s1", 32'(bus_a.s1), 32'd1);
      chk("single_s0", 32'(bus_a.s0), 32'd0);
      chk("single_grant", 32'(bus_a.grant), 32'h4);
      chk("single_early_valid", 32'(bus_a.out_valid), 32'd0);
      bus_a.req = 4'd0;
      tick();
      chk("single_valid", 32'(bus_a.out_valid), 32'd1);
      chk("single_data",  32'(bus_a.out_data),  32'd1);
      chk("single_chan",  32'(bus_a.out_chan),  32'd2);
      tick();
      chk("single_done_valid", 32'(bus_a.out_valid), 32'd0);
      chk("single_done_grant", 32'(bus_a.grant), 32'd0);
      chk("single_cnt", 32'(bus_a.sample_cnt), 32'd1);

      // Round robin from a fresh pointer
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      r_pat_a = 4'b1010; bus_a.req = 4'b1111;
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         exp_pat = r_pat_a;
         chk("rr_valid", 32'(bus_a.out_valid), 32'd1);
         chk("rr_chan",  32'(bus_a.out_chan),  32'(k % 4));
         chk("rr_data",  32'(bus_a.out_data),  32'(exp_pat[k % 4]));
         if (k == 4) bus_a.req = 4'd0;
         tick();
         chk("rr_gap_valid", 32'(bus_a.out_valid), 32'd0);
         if (k < 4) begin
            tick();
            tick();
         end
      end
      chk("rr_cnt", 32'(bus_a.sample_cnt), 32'd5);

      // Backpressure on channel 1 while the mux input toggles
      bus_a.out_ready = 1'b0; r_pat_a = 4'b0010; bus_a.req = 4'b0010;
      tick();
      chk("bp_grant", 32'(bus_a.grant), 32'h2);
      bus_a.req = 4'd0;
      tick();
      chk("bp_valid0", 32'(bus_a.out_valid), 32'd1);
      for (int i = 0; i < 6; i++) begin
         r_pat_a = ~r_pat_a;
         tick();
         chk("bp_valid", 32'(bus_a.out_valid), 32'd1);
         chk("bp_data",  32'(bus_a.out_data),  32'd1);
         chk("bp_chan",  32'(bus_a.out_chan),  32'd1);
         chk("bp_sel",   32'({bus_a.s1, bus_a.s0}), 32'd1);
         chk("bp_hold_grant", 32'(bus_a.grant), 32'h2);
         chk("bp_cnt_hold", 32'(bus_a.sample_cnt), 32'd5);
      end
      bus_a.out_ready = 1'b1;
      tick();
      chk("bp_release_valid", 32'(bus_a.out_valid), 32'd0);
      chk("bp_cnt", 32'(bus_a.sample_cnt), 32'd6);

      // Pointer wraps past 2,3 to reach channel 0, then channel 1
      r_pat_a = 4'b0001; bus_a.req = 4'b0011;
      tick();
      chk("skip_grant0", 32'(bus_a.grant), 32'h1);
      tick();
      chk("skip_chan0", 32'(bus_a.out_chan), 32'd0);
      chk("skip_data0", 32'(bus_a.out_data), 32'd1);
      tick();
      chk("skip_hs_valid", 32'(bus_a.out_valid), 32'd0);
      tick();
      chk("skip_grant1", 32'(bus_a.grant), 32'h2);
      tick();
      chk("skip_chan1", 32'(bus_a.out_chan), 32'd1);
      chk("skip_data1", 32'(bus_a.out_data), 32'd0);
      bus_a.req = 4'd0;
      tick();
      chk("skip_cnt", 32'(bus_a.sample_cnt), 32'd8);

      // SETTLE=4: latency, counter wrap, reset during settle
      r_pat_b = 4'b0001; bus_b.req = 4'b0001; bus_b.out_ready = 1'b1;
      tick();
      chk("s4_grant", 32'(bus_b.grant), 32'h1);
      tick(); tick(); tick();
      chk("s4_not_yet", 32'(bus_b.out_valid), 32'd0);
      tick();
      chk("s4_valid", 32'(bus_b.out_valid), 32'd1);
      chk("s4_data",  32'(bus_b.out_data),  32'd1);
      tick();
      chk("s4_cnt1", 32'(bus_b.sample_cnt), 32'd1);
      repeat (254 * 6) tick();
      chk("s4_cnt255", 32'(bus_b.sample_cnt), 32'd255);
      repeat (6) tick();
      chk("s4_cnt_wrap", 32'(bus_b.sample_cnt), 32'd0);
      tick();
      chk("s4_regrant", 32'(bus_b.grant), 32'h1);
      bus_b.req = 4'd0;
      tick();
      #2;
      rst_n_b = 1'b0;
      #1;
      chk("s4_rst_valid", 32'(bus_b.out_valid), 32'd0);
      chk("s4_rst_grant", 32'(bus_b.grant), 32'd0);
      chk("s4_rst_cnt",   32'(bus_b.sample_cnt), 32'd0);
      #1;
      rst_n_b = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("s4_no_valid", 32'(bus_b.out_valid), 32'd0);
      end
      bus_b.req = 4'b1001;
      tick();
      chk("s4_ptr_reset", 32'(bus_b.grant), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
